id_control_stage: RTL and testbench
===================================

Name: id_control_stage

Overview:
- Decode-stage control block for the 5-stage ARM pipeline.
- Combines three functions:
  - a 32-bit PC+4 adder;
  - an ARM instruction control decoder;
  - a bubble (NOP-insertion) mux.
- Registers the muxed control bundle, so it feeds the ID/EX control fields one cycle later.
- Source instruction is the IF/ID instruction word.

Parameters:
- DATA_W, 32, width of PC, adder operands and instruction.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all registered outputs.
- enable  in  1  1 = capture new control bundle; 0 = hold.
- bubble  in  1  1 = force decoded control bundle to all-zero (NOP).
- pc_current  in  32  current PC.
- pc_plus_4  out  32  combinational pc_current + 4.
- instruction  in  32  instruction word from IF/ID.
- reg_write_enable  out  1  registered RegWrite.
- mem_write_enable  out  1  registered MemWrite.
- mem_to_reg_select  out  1  registered MemtoReg (1 = load data).
- alu_source_select  out  1  registered ALUSrc (1 = immediate).
- status_bits  out  2  registered; [0] = S (update flags), [1] = L (branch-with-link).
- alu_operation  out  2  registered; 00 ADD, 01 SUB, 10 AND, 11 ORR.
- pc_source_select  out  1  registered branch select.

Behaviour:
- Adder:
  - pc_plus_4 = pc_current + 4, combinational.
  - Modulo 2^32; carry discarded (0xFFFFFFFC -> 0x00000000).
- Decoder (combinational; uses instr[27:20]; the condition field is ignored, as condition evaluation happens elsewhere):
  - instruction == 0x00000000: NOP, every control signal 0, regardless of other rules.
  - Data processing (instr[27:26] = 00):
    - alu_source_select = instr[25]; status_bits[0] = instr[20].
    - Opcode instr[24:21] mapping:
      - AND 0000 -> 10
      - SUB 0010, RSB 0011, CMP 1010 -> 01
      - ADD 0100, CMN 1011 -> 00
      - ORR 1100 -> 11
      - all others -> 00
    - reg_write_enable = 1, except opcodes 10xx (TST/TEQ/CMP/CMN) -> 0.
    - mem_write_enable = 0; mem_to_reg_select = 0; pc_source_select = 0.
  - Load/store (instr[27:26] = 01):
    - alu_source_select = ~instr[25] (immediate offset); alu_operation = instr[23] ? 00 : 01.
    - Load (L = instr[20] = 1): reg_write_enable = 1, mem_to_reg_select = 1.
    - Store (L = 0): mem_write_enable = 1.
    - status_bits = 00.
  - Branch (instr[27:25] = 101):
    - pc_source_select = 1; status_bits[1] = instr[24].
    - reg_write_enable = instr[24] (link write).
    - All other signals 0.
  - All other encodings (block transfer, coprocessor, SWI): all signals 0.
- Bubble mux: bubble = 1 -> every control field forced to 0 (including status_bits); bubble = 0 -> pass-through.
- Register:
  - On rising clk: reset = 1 -> all control outputs 0.
  - Else if enable = 1 -> capture the muxed bundle; else hold.
  - Latency: one cycle from instruction/bubble to outputs.
  - Reset has priority over enable.
  - Reset asserted mid-stream clears on the next edge; the first valid bundle appears on the edge after reset deasserts.
  - pc_plus_4 is unaffected by reset.

Decomposition:
- Shared package:
  - ALU op constants ALU_ADD/ALU_SUB/ALU_AND/ALU_ORR.
  - Instruction-class field constants.
  - A packed control-bundle struct (7 fields, 9 bits).
- One natural sub-module: id_control_decoder (pure combinational decode).
- The adder, mux and register stay inline.

Test Plan:
- Reset: reset = 1 for 2 edges with instruction 0xE2110000 -> all control outputs 0. Deassert -> next edge: RegWrite 1, ALUSrc 1, status 01, ALU 10, others 0.
- Data/memory decode, each held one cycle; ALUSrc 0 and status 00 where not stated:
  - 0xE0805183 (ADD reg) -> RegWrite 1, ALU 00.
  - 0xE7D12000 (LDRB) -> RegWrite 1, MemtoReg 1, ALU 00.
  - 0xE58A5000 (STR) -> MemWrite 1, ALUSrc 1, RegWrite 0, ALU 00.
- Branches:
  - 0x1AFFFFFD (BNE) -> PCSrc 1, RegWrite 0, status 00.
  - 0xDB000009 (BLLE) -> PCSrc 1, RegWrite 1, status 10.
- NOP/bubble:
  - 0x00000000 -> all 0.
  - 0xE2110000 with bubble = 1 -> all 0; bubble drops -> ANDS bundle next edge.
- Enable hold: capture STR, then enable = 0 and apply ADD -> outputs remain the STR bundle until enable = 1.
- Adder: pc_current 0, 4, 0x7FFFFFFC, 0xFFFFFFFC -> pc_plus_4 4, 8, 0x80000000, 0x00000000, combinationally and independent of reset.

Source files
------------

// File: rtl/id_control_stage_pkg.sv
// Shared types and constants for the ID-stage control path: ALU op codes,
// instruction-class field values and the packed control bundle.
package id_control_stage_pkg;

   localparam int DATA_W = 32;

   // ALU operation encodings driven on alu_operation
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   // Instruction-class values of instr[27:26] / instr[27:25]
   localparam logic [1:0] CLASS_DATA_PROC = 2'b00;
   localparam logic [1:0] CLASS_LOAD_STORE = 2'b01;
   localparam logic [2:0] CLASS_BRANCH = 3'b101;

   // Data-processing opcodes (instr[24:21]) that need a specific ALU op
   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_RSB = 4'b0011;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_CMP = 4'b1010;
   localparam logic [3:0] OP_CMN = 4'b1011;
   localparam logic [3:0] OP_ORR = 4'b1100;

   // Control bundle: 9 bits, MSB first as listed
   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic [1:0] status;     // [0] = S, [1] = L (link)
      logic [1:0] alu_op;
      logic       pc_src;
   } ctrl_t;

   // Map a data-processing opcode onto the reduced ALU op set
   function automatic logic [1:0] dp_alu_op(input logic [3:0] opcode);
      logic [1:0] op;
      case (opcode)
         OP_AND:                 op = ALU_AND;
         OP_SUB, OP_RSB, OP_CMP: op = ALU_SUB;
         OP_ADD, OP_CMN:         op = ALU_ADD;
         OP_ORR:                 op = ALU_ORR;
         default:                op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/id_control_decoder.sv
// Pure combinational ARM control decoder. The condition field is ignored;
// condition evaluation happens downstream.
module id_control_decoder
   import id_control_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] instruction,
   output ctrl_t             ctrl
);

   logic [3:0] opcode_s;
   assign opcode_s = instruction[24:21];

   // Decode instruction class and fields into the control bundle
   always_comb begin
      ctrl = '0;
      if (instruction == {DATA_W{1'b0}}) begin
         ctrl = '0;
      end else if (instruction[27:26] == CLASS_DATA_PROC) begin
         ctrl.alu_src   = instruction[25];
         ctrl.status[0] = instruction[20];
         ctrl.alu_op    = dp_alu_op(opcode_s);
         // TST/TEQ/CMP/CMN only set flags, no register result
         ctrl.reg_write = (opcode_s[3:2] != 2'b10);
      end else if (instruction[27:26] == CLASS_LOAD_STORE) begin
         // I = 0 means immediate offset; U selects add vs subtract offset
         ctrl.alu_src    = ~instruction[25];
         ctrl.alu_op     = instruction[23] ? ALU_ADD : ALU_SUB;
         ctrl.reg_write  = instruction[20];
         ctrl.mem_to_reg = instruction[20];
         ctrl.mem_write  = ~instruction[20];
      end else if (instruction[27:25] == CLASS_BRANCH) begin
         ctrl.pc_src    = 1'b1;
         ctrl.status[1] = instruction[24];
         ctrl.reg_write = instruction[24];
      end else begin
         // Block transfer, coprocessor, SWI: no control activity
         ctrl = '0;
      end
   end

endmodule

// File: rtl/id_control_stage.sv
// Decode-stage control block: PC+4 adder, control decoder, bubble mux and
// the register feeding the ID/EX control fields.
module id_control_stage
   import id_control_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              bubble,
   input  logic [DATA_W-1:0] pc_current,
   output logic [DATA_W-1:0] pc_plus_4,
   input  logic [DATA_W-1:0] instruction,
   output logic              reg_write_enable,
   output logic              mem_write_enable,
   output logic              mem_to_reg_select,
   output logic              alu_source_select,
   output logic [1:0]        status_bits,
   output logic [1:0]        alu_operation,
   output logic              pc_source_select
);

   ctrl_t decoded_s;
   ctrl_t muxed_s;
   ctrl_t ctrl_r;

   // Carry out is discarded, so the PC wraps modulo 2^DATA_W
   assign pc_plus_4 = pc_current + DATA_W'(4);

   id_control_decoder #(
      .DATA_W (DATA_W)
   ) u_decoder (
      .instruction (instruction),
      .ctrl        (decoded_s)
   );

   // Bubble mux: replace the decoded bundle with a NOP when stalling
   always_comb begin
      muxed_s = '0;
      if (bubble) begin
         muxed_s = '0;
      end else begin
         muxed_s = decoded_s;
      end
   end

   // Control register: reset clears, enable captures, otherwise hold
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_r <= '0;
      end else if (enable) begin
         ctrl_r <= muxed_s;
      end else begin
         ctrl_r <= ctrl_r;
      end
   end

   assign reg_write_enable  = ctrl_r.reg_write;
   assign mem_write_enable  = ctrl_r.mem_write;
   assign mem_to_reg_select = ctrl_r.mem_to_reg;
   assign alu_source_select = ctrl_r.alu_src;
   assign status_bits       = ctrl_r.status;
   assign alu_operation     = ctrl_r.alu_op;
   assign pc_source_select  = ctrl_r.pc_src;

endmodule

// File: tb/tb_id_control_stage.sv
// Directed, table-driven bench for id_control_stage.
module tb_id_control_stage;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        bubble;
   logic [31:0] pc_current;
   logic [31:0] pc_plus_4;
   logic [31:0] instruction;
   logic        reg_write_enable;
   logic        mem_write_enable;
   logic        mem_to_reg_select;
   logic        alu_source_select;
   logic [1:0]  status_bits;
   logic [1:0]  alu_operation;
   logic        pc_source_select;

   int tests;
   int fails;

   id_control_stage #(.DATA_W(32)) dut (
      .clk               (clk),
      .reset             (reset),
      .enable            (enable),
      .bubble            (bubble),
      .pc_current        (pc_current),
      .pc_plus_4         (pc_plus_4),
      .instruction       (instruction),
      .reg_write_enable  (reg_write_enable),
      .mem_write_enable  (mem_write_enable),
      .mem_to_reg_select (mem_to_reg_select),
      .alu_source_select (alu_source_select),
      .status_bits       (status_bits),
      .alu_operation     (alu_operation),
      .pc_source_select  (pc_source_select)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bundle order: {RegWrite, MemWrite, MemtoReg, ALUSrc, status[1:0], ALU[1:0], PCSrc}
   logic [8:0] bundle;
   assign bundle = {reg_write_enable, mem_write_enable, mem_to_reg_select,
                    alu_source_select, status_bits, alu_operation, pc_source_select};

   function automatic logic [8:0] mk(input logic rw, input logic mw, input logic m2r,
                                     input logic src, input logic [1:0] st,
                                     input logic [1:0] alu, input logic pc);
      return {rw, mw, m2r, src, st, alu, pc};
   endfunction

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic        bub;
      logic [8:0]  exp;
   } vec_t;

   vec_t vecs[14];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check9(input string name, input logic [8:0] act, input logic [8:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   logic [8:0] ands_b;
   logic [8:0] str_b;
   logic [8:0] add_b;
   logic [31:0] pcs [4];
   logic [31:0] pcx [4];

   initial begin
      tests = 0;
      fails = 0;
      ands_b = mk(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 2'b10, 1'b0);
      str_b  = mk(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
      add_b  = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

      vecs[0]  = '{"ADD reg",   32'hE0805183, 1'b0, add_b};
      vecs[1]  = '{"LDRB",      32'hE7D12000, 1'b0, mk(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0)};
      vecs[2]  = '{"STR",       32'hE58A5000, 1'b0, str_b};
      vecs[3]  = '{"BNE",       32'h1AFFFFFD, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1)};
      vecs[4]  = '{"BLLE",      32'hDB000009, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b1)};
      vecs[5]  = '{"NOP zero",  32'h00000000, 1'b0, 9'd0};
      vecs[6]  = '{"CMP imm S", 32'hE3500000, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0)};
      vecs[7]  = '{"ORR reg",   32'hE1811002, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 1'b0)};
      vecs[8]  = '{"SUB reg",   32'hE0412003, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0)};
      vecs[9]  = '{"STR neg",   32'hE5050004, 1'b0, mk(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0)};
      vecs[10] = '{"LDM",       32'hE8BD0001, 1'b0, 9'd0};
      vecs[11] = '{"SWI",       32'hEF000000, 1'b0, 9'd0};
      vecs[12] = '{"AND cond",  32'hE0000000, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0)};
      vecs[13] = '{"ANDS bub",  32'hE2110000, 1'b1, 9'd0};

      pcs[0] = 32'h00000000; pcx[0] = 32'h00000004;
      pcs[1] = 32'h00000004; pcx[1] = 32'h00000008;
      pcs[2] = 32'h7FFFFFFC; pcx[2] = 32'h80000000;
      pcs[3] = 32'hFFFFFFFC; pcx[3] = 32'h00000000;

      // Reset for two edges with ANDS on the instruction bus
      reset = 1'b1;
      enable = 1'b1;
      bubble = 1'b0;
      pc_current = 32'h0;
      instruction = 32'hE2110000;
      tick();
      check9("reset edge1", bundle, 9'd0);
      tick();
      check9("reset edge2", bundle, 9'd0);

      // Adder is combinational and ignores reset
      for (int i = 0; i < 4; i++) begin
         pc_current = pcs[i];
         #1;
         check32($sformatf("pc+4 in reset %0d", i), pc_plus_4, pcx[i]);
      end

      reset = 1'b0;
      tick();
      check9("ANDS after reset", bundle, ands_b);

      // Table of single-cycle decodes
      for (int i = 0; i < 14; i++) begin
         instruction = vecs[i].instr;
         bubble = vecs[i].bub;
         tick();
         check9(vecs[i].name, bundle, vecs[i].exp);
      end

      // Bubble drops: ANDS bundle on the next edge
      bubble = 1'b0;
      tick();
      check9("bubble release", bundle, ands_b);

      // Enable hold: capture STR, then hold while ADD is presented
      instruction = 32'hE58A5000;
      tick();
      check9("hold capture STR", bundle, str_b);
      enable = 1'b0;
      instruction = 32'hE0805183;
      tick();
      check9("hold cycle1", bundle, str_b);
      tick();
      check9("hold cycle2", bundle, str_b);
      enable = 1'b1;
      tick();
      check9("hold release ADD", bundle, add_b);

      // Reset beats a deasserted enable, mid-stream
      enable = 1'b0;
      reset = 1'b1;
      tick();
      check9("reset over hold", bundle, 9'd0);
      reset = 1'b0;
      enable = 1'b1;
      instruction = 32'hE2110000;
      tick();
      check9("ANDS after midreset", bundle, ands_b);

      // Adder outside reset
      for (int i = 0; i < 4; i++) begin
         pc_current = pcs[3 - i];
         #1;
         check32($sformatf("pc+4 run %0d", i), pc_plus_4, pcx[3 - i]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
